pixel_readout_ctrl: RTL and testbench
=====================================

Name: pixel_readout_ctrl

Overview:
Frame sequencer for the pixel array front end. It drives the pixel erase and expose controls and generates the gray-coded ADC ramp code during conversion. It then strobes the per-row read enables that feed the downstream databus, which gray-to-binary converts and packs the two pixel words. One start pulse runs exactly one frame: ERASE -> EXPOSE -> CONVERT -> READ -> DONE.

Parameters:
DATA_W, 8, ADC code width; CONVERT lasts 2**DATA_W cycles.
ERASE_CYCLES, 5, cycles erase is held high (>=1).
NUM_ROWS, 2, pixel rows read out; read_row bit i drives databus readN, with N = i+1.
READ_CYCLES, 2, cycles each row's read enable is held (>=1).
EXP_W, 8, width of the exposure-time input.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  reset, synchronous, active-high.
start  in  1  frame request; sampled only in IDLE.
expose_time  in  EXP_W  exposure length in cycles; latched when start is accepted.
erase  out  1  pixel erase control.
expose  out  1  pixel expose control.
convert  out  1  high while the ramp is running.
convert_gray  out  DATA_W  gray-coded ramp code to the pixel comparators/latches.
read_row  out  NUM_ROWS  one-hot row read enable (all zero outside READ).
data_valid  out  1  downstream databus output is valid this cycle.
busy  out  1  high in every state except IDLE.
frame_done  out  1  one-cycle pulse at the end of a frame.

Behaviour:
- Reset: state IDLE. All outputs 0. Internal counters 0. Latched exposure 0. Reset overrides everything, including mid-frame operation; outputs read 0 on the first cycle after the reset edge.
- All outputs are registered or decoded from registered state only; no combinational path from start to any output.
- IDLE: start=1 at edge k -> ERASE from cycle k+1. The same edge latches exp_len = max(expose_time, 1). start outside IDLE is ignored, and expose_time changes mid-frame have no effect.
- ERASE: erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
- EXPOSE: expose=1 for exactly exp_len cycles, then CONVERT. An expose_time of 0 behaves as 1.
- CONVERT: convert=1 for 2**DATA_W cycles. The internal binary count b runs 0 .. 2**DATA_W-1, one step per cycle. convert_gray = b ^ (b>>1) in the same cycle as b. The count does not wrap inside a frame. convert_gray=0 outside CONVERT.
- READ: rows are read in order 0..NUM_ROWS-1. read_row = one-hot(row) is held for READ_CYCLES cycles per row. data_valid=1 only on the last cycle of each row's window, giving NUM_ROWS valid pulses per frame. After the last row the state goes to DONE.
- DONE: one cycle. frame_done=1 and busy=1. Next state IDLE. start is not accepted in DONE.
- Frame length from the start edge: frame_done is asserted in cycle k + ERASE_CYCLES + exp_len + 2**DATA_W + NUM_ROWS*READ_CYCLES + 1. With defaults and exp_len=10, that is k+276.
- Exactly one of erase, expose, convert, or a read_row bit is high in any non-IDLE/non-DONE cycle; they never overlap.

Optional Feature:
Macro PIXEL_READOUT_CONTINUOUS_EN.
- Defined: adds input port continuous (1 bit). When continuous=1 during DONE, the next state is ERASE instead of IDLE, and exp_len is re-latched from expose_time in that DONE cycle. frame_done still pulses every frame. busy stays high between frames.
- Undefined: no continuous port; DONE always returns to IDLE.

Decomposition:
- Shared package pixel_pkg holds:
  - state enum {IDLE, ERASE, EXPOSE, CONVERT, READ, DONE};
  - default constants for DATA_W, ERASE_CYCLES, NUM_ROWS, READ_CYCLES;
  - a bin2gray function, which keeps gray coding consistent with the downstream gray-to-binary stage.
- One sub-module: gray_ramp_counter (enable, clear, binary count, gray output, terminal-count flag), instantiated once for CONVERT.
- The phase counters for ERASE, EXPOSE and READ share one down-counter in the top FSM.

Test Plan:
1. Apply reset for 3 cycles with start=1 -> all outputs 0, busy=0; no frame starts until start is seen after reset deasserts.
2. Defaults, expose_time=10, start pulse at cycle k:
   - erase high k+1..k+5; expose high k+6..k+15; convert high k+16..k+271.
   - convert_gray sequence 0x00,0x01,0x03,0x02,0x06, ending at 0x80.
   - read_row=01 at k+272..k+273, then 10 at k+274..k+275; data_valid high at k+273 and k+275.
   - frame_done high at k+276 only; busy high k+1..k+276.
3. expose_time=0 -> expose high exactly 1 cycle; frame_done at k+267.
4. During CONVERT, pulse start and change expose_time to 50 -> no effect on the current frame. The next frame started from IDLE uses 50 (frame_done at k+316).
5. Assert reset when convert_gray=0x56 (b=100) -> next cycle all outputs 0 and state IDLE. A subsequent start gives a full, correct frame beginning at ramp code 0.
6. With PIXEL_READOUT_CONTINUOUS_EN defined, continuous=1 and expose_time=10 -> back-to-back frames. frame_done pulses every 276 cycles, erase rises the cycle after each frame_done, and busy never drops.

Source files
------------

// File: rtl/pixel_pkg.sv
// Shared types and defaults for the pixel readout sequencer: frame state enum,
// default geometry constants and the gray encoder shared with the databus decoder.
package pixel_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        DONE
    } state_t;

    localparam int DEF_DATA_W       = 8;
    localparam int DEF_ERASE_CYCLES = 5;
    localparam int DEF_NUM_ROWS     = 2;
    localparam int DEF_READ_CYCLES  = 2;
    localparam int DEF_EXP_W        = 8;

    // Callers truncate to their own width; the low bits are unaffected by zero-extension.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_ramp_counter.sv
// Binary up-counter for the ADC ramp with a gray-coded copy and a terminal-count flag.
module gray_ramp_counter
    import pixel_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    output logic [DATA_W-1:0] count,
    output logic [DATA_W-1:0] gray,
    output logic              tc
);

    // NOTE: reset is synchronous here, so it sits inside the clocked block rather
    // than in the sensitivity list; all state updates use non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + DATA_W'(1);
        end
    end

    assign gray = DATA_W'(bin2gray(32'(count)));
    assign tc   = &count;

endmodule

// File: rtl/pixel_readout_ctrl.sv
// Frame sequencer ERASE -> EXPOSE -> CONVERT -> READ -> DONE for the pixel array.
// Optional back-to-back frames are enabled with `define PIXEL_READOUT_CONTINUOUS_EN.
module pixel_readout_ctrl
    import pixel_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int ERASE_CYCLES = DEF_ERASE_CYCLES,
    parameter int NUM_ROWS     = DEF_NUM_ROWS,
    parameter int READ_CYCLES  = DEF_READ_CYCLES,
    parameter int EXP_W        = DEF_EXP_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [EXP_W-1:0]    expose_time,
`ifdef PIXEL_READOUT_CONTINUOUS_EN
    input  logic                continuous,
`endif
    output logic                erase,
    output logic                expose,
    output logic                convert,
    output logic [DATA_W-1:0]   convert_gray,
    output logic [NUM_ROWS-1:0] read_row,
    output logic                data_valid,
    output logic                busy,
    output logic                frame_done
);

    localparam int ERASE_W = $clog2(ERASE_CYCLES + 1);
    localparam int READ_W  = $clog2(READ_CYCLES + 1);
    localparam int PHASE_W = (ERASE_W > READ_W) ? ERASE_W : READ_W;
    localparam int CNT_W   = (EXP_W > PHASE_W) ? EXP_W : PHASE_W;
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [CNT_W-1:0] ERASE_LOAD = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_CYCLES - 1);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(NUM_ROWS - 1);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [ROW_W-1:0]  row, row_next;
    logic [EXP_W-1:0]  exp_len, exp_len_next;
    logic [EXP_W-1:0]  exp_req;
    logic              restart;
    logic              ramp_tc;
    logic [DATA_W-1:0] ramp_count;
    logic [DATA_W-1:0] ramp_gray;

    // A zero exposure request is stretched to one cycle so EXPOSE is never skipped.
    assign exp_req = (expose_time == '0) ? EXP_W'(1) : expose_time;

`ifdef PIXEL_READOUT_CONTINUOUS_EN
    assign restart = continuous;
`else
    assign restart = 1'b0;
`endif

    // NOTE: every signal driven here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        state_next   = state;
        cnt_next     = cnt;
        row_next     = row;
        exp_len_next = exp_len;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next   = ERASE;
                    cnt_next     = ERASE_LOAD;
                    exp_len_next = exp_req;
                end
            end
            ERASE: begin
                if (cnt == '0) begin
                    state_next = EXPOSE;
                    cnt_next   = CNT_W'(exp_len) - CNT_W'(1);
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            EXPOSE: begin
                if (cnt == '0) begin
                    state_next = CONVERT;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            CONVERT: begin
                if (ramp_tc) begin
                    state_next = READ;
                    cnt_next   = READ_LOAD;
                    row_next   = '0;
                end
            end
            READ: begin
                if (cnt == '0) begin
                    if (row == LAST_ROW) begin
                        state_next = DONE;
                    end else begin
                        row_next = row + ROW_W'(1);
                        cnt_next = READ_LOAD;
                    end
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            DONE: begin
                if (restart) begin
                    state_next   = ERASE;
                    cnt_next     = ERASE_LOAD;
                    exp_len_next = exp_req;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            row     <= '0;
            exp_len <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            row     <= row_next;
            exp_len <= exp_len_next;
        end
    end

    gray_ramp_counter #(
        .DATA_W(DATA_W)
    ) u_ramp (
        .clk   (clk),
        .reset (reset),
        .enable(state == CONVERT),
        .clear (state != CONVERT),
        .count (ramp_count),
        .gray  (ramp_gray),
        .tc    (ramp_tc)
    );

    // Outputs are pure decodes of registered state, so start never reaches them directly.
    assign erase        = (state == ERASE);
    assign expose       = (state == EXPOSE);
    assign convert      = (state == CONVERT);
    assign convert_gray = convert ? ramp_gray : '0;
    assign read_row     = (state == READ) ? (NUM_ROWS'(1) << row) : '0;
    assign data_valid   = (state == READ) && (cnt == '0);
    assign busy         = (state != IDLE);
    assign frame_done   = (state == DONE);

endmodule

// File: tb/tb_pixel_readout_ctrl.sv
// Self-checking bench for pixel_readout_ctrl: randomized and directed frames compared
// every cycle against a frame-timeline model computed from phase offsets.
module tb_pixel_readout_ctrl;

    localparam int E  = 5;
    localparam int C  = 256;
    localparam int NR = 2;
    localparam int RC = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] expose_time = 8'd0;
    logic       continuous = 1'b0;

    logic       erase, expose, convert, data_valid, busy, frame_done;
    logic [7:0] convert_gray;
    logic [1:0] read_row;

    int total = 0;
    int bad   = 0;

    // Reference model state: position within the current frame (1 = first ERASE cycle).
    bit m_active = 1'b0;
    int m_t      = 0;
    int m_el     = 1;

    pixel_readout_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .expose_time (expose_time),
`ifdef PIXEL_READOUT_CONTINUOUS_EN
        .continuous  (continuous),
`endif
        .erase       (erase),
        .expose      (expose),
        .convert     (convert),
        .convert_gray(convert_gray),
        .read_row    (read_row),
        .data_valid  (data_valid),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0d el=%0d time=%0t)", tag, got, want, m_t, m_el, $time);
        end
    endtask

    function automatic int frame_len(input int el);
        return E + el + C + NR * RC + 1;
    endfunction

    // Expected output word {erase,expose,convert,gray,read_row,data_valid,busy,frame_done}.
    function automatic logic [15:0] model_outs(input bit act, input int t, input int el);
        logic       o_er, o_ex, o_cv, o_dv, o_bz, o_fd;
        logic [7:0] o_g;
        logic [1:0] o_rr;
        int b, r;
        o_er = 0; o_ex = 0; o_cv = 0; o_dv = 0; o_bz = 0; o_fd = 0;
        o_g = '0; o_rr = '0;
        if (act) begin
            o_bz = 1;
            if (t <= E) begin
                o_er = 1;
            end else if (t <= E + el) begin
                o_ex = 1;
            end else if (t <= E + el + C) begin
                o_cv = 1;
                b    = t - E - el - 1;
                o_g  = 8'(b ^ (b >> 1));
            end else if (t < frame_len(el)) begin
                r    = t - E - el - C - 1;
                o_rr = 2'(1 << (r / RC));
                o_dv = ((r % RC) == RC - 1);
            end else begin
                o_fd = 1;
            end
        end
        return {o_er, o_ex, o_cv, o_g, o_rr, o_dv, o_bz, o_fd};
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare all outputs.
    task automatic step(input bit rst, input bit st, input logic [7:0] et, input bit ct);
        bit cont_eff;
        int el_req;
        reset       = rst;
        start       = st;
        expose_time = et;
        continuous  = ct;
`ifdef PIXEL_READOUT_CONTINUOUS_EN
        cont_eff = ct;
`else
        cont_eff = 1'b0;
`endif
        el_req = (et == 0) ? 1 : int'(et);
        @(posedge clk);
        #1;
        if (rst) begin
            m_active = 1'b0;
            m_t      = 0;
        end else if (m_active) begin
            if (m_t == frame_len(m_el)) begin
                if (cont_eff) begin
                    m_t  = 1;
                    m_el = el_req;
                end else begin
                    m_active = 1'b0;
                    m_t      = 0;
                end
            end else begin
                m_t++;
            end
        end else if (st) begin
            m_active = 1'b1;
            m_t      = 1;
            m_el     = el_req;
        end
        check("outs",
              {erase, expose, convert, convert_gray, read_row, data_valid, busy, frame_done},
              model_outs(m_active, m_t, m_el));
        @(negedge clk);
    endtask

    // Start a frame from IDLE and measure the start-to-frame_done distance on the DUT.
    task automatic run_frame(input logic [7:0] et, input int want_len, input bit noise);
        int n;
        step(0, 0, et, 0);
        step(0, 1, et, 0);
        n = 1;
        while (frame_done !== 1'b1 && n < 600) begin
            if (noise && convert === 1'b1)
                step(0, 1'($urandom_range(0, 1)), 8'd50, 0);
            else
                step(0, 0, noise ? 8'($urandom_range(0, 255)) : et, 0);
            n++;
        end
        check("frame_len", n, want_len);
    endtask

    initial begin
        int guard;

        // Reset held with start asserted: nothing may start.
        for (int i = 0; i < 3; i++) step(1, 1, 8'd10, 0);
        check("rst_outs", {erase, expose, convert, convert_gray, read_row, data_valid, busy, frame_done}, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 8'd10, 0);
        check("idle_busy", busy, 1'b0);

        // Nominal frame, zero exposure, and mid-frame disturbances.
        run_frame(8'd10, 276, 0);
        run_frame(8'd0, 267, 0);
        run_frame(8'd10, 276, 1);
        run_frame(8'd50, 316, 0);

        // Reset in the middle of the ramp at b=100.
        step(0, 0, 8'd10, 0);
        step(0, 1, 8'd10, 0);
        guard = 0;
        while (m_t != E + 10 + 1 + 100 && guard < 400) begin
            step(0, 0, 8'd10, 0);
            guard++;
        end
        check("gray_b100", convert_gray, 8'h56);
        step(1, 0, 8'd10, 0);
        check("rst_mid", {erase, expose, convert, convert_gray, read_row, data_valid, busy, frame_done}, 0);
        step(0, 0, 8'd10, 0);
        run_frame(8'd10, 276, 0);

`ifdef PIXEL_READOUT_CONTINUOUS_EN
        // Back-to-back frames: busy never drops and frame_done repeats every 276 cycles.
        begin
            int gap;
            step(0, 0, 8'd10, 1);
            step(0, 1, 8'd10, 1);
            for (int f = 0; f < 3; f++) begin
                gap = 1;
                while (frame_done !== 1'b1 && gap < 600) begin
                    step(0, 0, 8'd10, 1);
                    check("cont_busy", busy, 1'b1);
                    gap++;
                end
                check("cont_period", gap, 276);
                step(0, 0, 8'd10, 1);
                check("cont_erase", erase, 1'b1);
            end
            for (int i = 0; i < 300; i++) step(0, 0, 8'd10, 0);
        end
`endif

        // Random traffic: sporadic starts, wandering exposure, rare resets.
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(0, 1999) == 0),
                 ($urandom_range(0, 15) == 0),
                 8'($urandom_range(0, 40)),
                 ($urandom_range(0, 3) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
